// File: rtl/cpu_pkg.sv
// Shared types and encodings for the accumulator CPU control sequencer.
// CPU_SINGLE_STEP_EN adds the PAUSE state used for single-instruction stepping.
package cpu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_DEC,
        S_R1,
        S_R2,
        S_EX,
        S_ST,
        S_HALT
`ifdef CPU_SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_e;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;
    localparam logic [3:0] OP_GT    = 4'hD;
    localparam logic [3:0] OP_EQ    = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_GT  = 4'b1110;
    localparam logic [ALU_W-1:0] ALU_EQ  = 4'b1111;

    localparam logic PC_SEL_INC  = 1'b0;
    localparam logic PC_SEL_IR   = 1'b1;
    localparam logic MAR_SEL_PC  = 1'b0;
    localparam logic MAR_SEL_IR  = 1'b1;
    localparam logic MBR_SEL_MEM = 1'b0;
    localparam logic MBR_SEL_ACC = 1'b1;
    localparam logic ACC_SEL_MBR = 1'b0;
    localparam logic ACC_SEL_ALU = 1'b1;

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// Control bus between the sequencer (master) and the CPU datapath (slave).
// CPU_SINGLE_STEP_EN adds the step input.
interface cpu_control_sequencer_if #(
    parameter int OPC_W = 4,
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic             start;
    logic [OPC_W-1:0] ir_opcode;
    logic             acc_zero;
`ifdef CPU_SINGLE_STEP_EN
    logic             step;
`endif
    logic             pc_we;
    logic             pc_sel;
    logic             mar_we;
    logic             mar_sel;
    logic             mbr_we;
    logic             mbr_sel;
    logic             ir_we;
    logic             acc_we;
    logic             acc_sel;
    logic             mem_we;
    logic [ALU_W-1:0] alu_op;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  start, ir_opcode, acc_zero,
`ifdef CPU_SINGLE_STEP_EN
        input  step,
`endif
        output pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel, ir_we,
               acc_we, acc_sel, mem_we, alu_op, busy, halted, instr_count
    );

    modport slave (
        output start, ir_opcode, acc_zero,
`ifdef CPU_SINGLE_STEP_EN
        output step,
`endif
        input  pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel, ir_we,
               acc_we, acc_sel, mem_we, alu_op, busy, halted, instr_count
    );

endinterface

// File: rtl/cpu_alu_op_decode.sv
// Maps an instruction opcode to the ALU operation code; non-ALU opcodes give ADD (0000).
module cpu_alu_op_decode
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] i_opcode,
    output logic [ALU_W-1:0] o_alu_op
);

    always_comb begin
        o_alu_op = ALU_ADD;
        case (i_opcode)
            OP_ADD:  o_alu_op = ALU_ADD;
            OP_SUB:  o_alu_op = ALU_SUB;
            OP_AND:  o_alu_op = ALU_AND;
            OP_OR:   o_alu_op = ALU_OR;
            OP_XOR:  o_alu_op = ALU_XOR;
            OP_SHL:  o_alu_op = ALU_SHL;
            OP_SHR:  o_alu_op = ALU_SHR;
            OP_GT:   o_alu_op = ALU_GT;
            OP_EQ:   o_alu_op = ALU_EQ;
            default: o_alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute FSM and retired-instruction counter for the 16-bit accumulator CPU.
// CPU_SINGLE_STEP_EN: each instruction ends in PAUSE until a step pulse.
module cpu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    cpu_control_sequencer_if.master ctrl
);

`ifdef CPU_SINGLE_STEP_EN
    localparam state_e S_NEXT = S_PAUSE;
`else
    localparam state_e S_NEXT = S_F0;
`endif

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_instr_count;
    logic [ALU_W-1:0] w_alu_op;

    cpu_alu_op_decode #(.OPC_W(OPC_W)) u_alu_op_decode (
        .i_opcode (ctrl.ir_opcode),
        .o_alu_op (w_alu_op)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DEC) r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign ctrl.instr_count = r_instr_count;
    assign ctrl.busy        = r_state inside {S_F0, S_F1, S_F2, S_DEC, S_R1, S_R2, S_EX, S_ST};
    assign ctrl.halted      = (r_state == S_HALT);

    always_comb begin
        w_next       = r_state;
        ctrl.pc_we   = 1'b0;
        ctrl.pc_sel  = PC_SEL_INC;
        ctrl.mar_we  = 1'b0;
        ctrl.mar_sel = MAR_SEL_PC;
        ctrl.mbr_we  = 1'b0;
        ctrl.mbr_sel = MBR_SEL_MEM;
        ctrl.ir_we   = 1'b0;
        ctrl.acc_we  = 1'b0;
        ctrl.acc_sel = ACC_SEL_MBR;
        ctrl.mem_we  = 1'b0;
        ctrl.alu_op  = ALU_ADD;
        case (r_state)
            S_IDLE: if (ctrl.start) w_next = S_F0;
            S_F0: begin
                ctrl.mar_we = 1'b1;
                w_next      = S_F1;
            end
            S_F1: begin
                ctrl.pc_we = 1'b1;
                w_next     = S_F2;
            end
            S_F2: begin
                ctrl.ir_we = 1'b1;
                w_next     = S_DEC;
            end
            S_DEC: begin
                case (ctrl.ir_opcode)
                    OP_NOP: w_next = S_NEXT;
                    OP_JMP: begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_sel = PC_SEL_IR;
                        w_next      = S_NEXT;
                    end
                    // Untaken branches leave PC alone; it already points past this word.
                    OP_JZ: begin
                        ctrl.pc_we  = ctrl.acc_zero;
                        ctrl.pc_sel = ctrl.acc_zero;
                        w_next      = S_NEXT;
                    end
                    OP_JNZ: begin
                        ctrl.pc_we  = !ctrl.acc_zero;
                        ctrl.pc_sel = !ctrl.acc_zero;
                        w_next      = S_NEXT;
                    end
                    OP_STORE: begin
                        ctrl.mar_we  = 1'b1;
                        ctrl.mar_sel = MAR_SEL_IR;
                        ctrl.mbr_we  = 1'b1;
                        ctrl.mbr_sel = MBR_SEL_ACC;
                        w_next       = S_ST;
                    end
                    OP_HALT: w_next = S_HALT;
                    default: begin
                        ctrl.mar_we  = 1'b1;
                        ctrl.mar_sel = MAR_SEL_IR;
                        w_next       = S_R1;
                    end
                endcase
            end
            S_R1: w_next = S_R2;
            S_R2: begin
                ctrl.mbr_we = 1'b1;
                w_next      = S_EX;
            end
            S_EX: begin
                ctrl.acc_we  = 1'b1;
                ctrl.acc_sel = (ctrl.ir_opcode == OP_LOAD) ? ACC_SEL_MBR : ACC_SEL_ALU;
                ctrl.alu_op  = w_alu_op;
                w_next       = S_NEXT;
            end
            S_ST: begin
                ctrl.mem_we = 1'b1;
                w_next      = S_NEXT;
            end
            S_HALT: if (ctrl.start) w_next = S_F0;
`ifdef CPU_SINGLE_STEP_EN
            S_PAUSE: if (ctrl.step) w_next = S_F0;
`endif
            default: w_next = S_IDLE;
        endcase
    end

endmodule
